// File: rtl/uc_fsm.sv
// Sequencing controller for a small accumulator-style datapath.
// Decodes the 6-bit opcode combinationally while running and keeps
// retired-instruction and taken-jump statistics.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset; datapath held in reset, waiting for start
// RESTART | one-cycle datapath reset before re-entering RUN
// RUN     | executing; control decoded from Opcode in the same cycle
// HALT    | HALT instruction retired; waiting for start
// ERR     | illegal opcode seen; waiting for start
module uc_fsm #(
    parameter int CNT_W = 16,
    parameter int TK_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic             z,
    input  logic             start,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we3,
    output logic             wez,
    output logic [2:0]       Op,
    output logic             dp_rst,
    output logic             running,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] retired,
    output logic [TK_W-1:0]  taken
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RESTART = 3'd1,
        RUN     = 3'd2,
        HALT    = 3'd3,
        ERR     = 3'd4
    } state_t;

    state_t state, state_nxt;
    logic   legal;
    logic   clr_cnt;

    // State register; reset drops straight back to IDLE, even mid-RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and control decode; outside RUN the datapath is held quiet.
    always_comb begin
        state_nxt = state;
        s_inc     = 1'b1;
        s_inm     = 1'b0;
        we3       = 1'b0;
        wez       = 1'b0;
        Op        = 3'b000;
        dp_rst    = 1'b1;
        legal     = 1'b0;
        clr_cnt   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    clr_cnt   = 1'b1;
                end
            end
            RESTART: begin
                state_nxt = RUN;
            end
            RUN: begin
                dp_rst = 1'b0;
                casez (Opcode)
                    6'b1?????: begin
                        Op    = Opcode[4:2];
                        we3   = 1'b1;
                        wez   = 1'b1;
                        legal = 1'b1;
                    end
                    6'b0000??: begin
                        we3   = 1'b1;
                        s_inm = 1'b1;
                        legal = 1'b1;
                    end
                    6'b000100: begin
                        s_inc = 1'b0;
                        legal = 1'b1;
                    end
                    6'b000101: begin
                        s_inc = ~z;
                        legal = 1'b1;
                    end
                    6'b000110: begin
                        s_inc = z;
                        legal = 1'b1;
                    end
                    6'b000111: begin
                        legal     = 1'b1;
                        state_nxt = HALT;
                    end
                    default: begin
                        state_nxt = ERR;
                    end
                endcase
            end
            HALT, ERR: begin
                if (start) begin
                    state_nxt = RESTART;
                    clr_cnt   = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign running = (state == RUN);
    assign halted  = (state == HALT);
    assign err     = (state == ERR);

    // Statistics: retired wraps, taken saturates; both clear when a run is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired <= '0;
            taken   <= '0;
        end else if (clr_cnt) begin
            retired <= '0;
            taken   <= '0;
        end else if (legal) begin
            retired <= retired + CNT_W'(1);
            if (!s_inc && (taken != '1)) begin
                taken <= taken + TK_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uc_fsm.sv
// Bench for uc_fsm: directed sequence followed by random opcodes, all
// checked against an instruction-level reference model.
module tb_uc_fsm;

    localparam int CNT_W = 16;
    localparam int TK_W  = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [5:0]       Opcode;
    logic             z;
    logic             start;
    logic             s_inc, s_inm, we3, wez, dp_rst;
    logic [2:0]       Op;
    logic             running, halted, err;
    logic [CNT_W-1:0] retired;
    logic [TK_W-1:0]  taken;

    int n_vec = 0;
    int n_err = 0;

    // model: 0 idle, 1 restart, 2 run, 3 halt, 4 err
    int m_mode = 0;
    int m_ret  = 0;
    int m_tk   = 0;

    uc_fsm #(.CNT_W(CNT_W), .TK_W(TK_W)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .z(z), .start(start),
        .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .Op(Op),
        .dp_rst(dp_rst), .running(running), .halted(halted), .err(err),
        .retired(retired), .taken(taken)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // 0 alu, 1 li, 2 j, 3 jz, 4 jnz, 5 halt, 6 illegal
    function automatic int kind(input int op);
        if (op >= 32) return 0;
        if (op < 4)   return 1;
        if (op == 4)  return 2;
        if (op == 5)  return 3;
        if (op == 6)  return 4;
        if (op == 7)  return 5;
        return 6;
    endfunction

    task automatic step(input logic [5:0] op, input logic zz, input logic st);
        int k;
        logic e_inc, e_inm, e_we3, e_wez, e_dp;
        logic [2:0] e_op;
        @(negedge clk);
        Opcode = op;
        z      = zz;
        start  = st;
        #1;
        k     = kind(int'(op));
        e_inc = 1'b1; e_inm = 1'b0; e_we3 = 1'b0; e_wez = 1'b0; e_op = 3'b000;
        e_dp  = (m_mode != 2);
        if (m_mode == 2) begin
            case (k)
                0: begin e_op = op[4:2]; e_we3 = 1'b1; e_wez = 1'b1; end
                1: begin e_we3 = 1'b1; e_inm = 1'b1; end
                2: e_inc = 1'b0;
                3: e_inc = ~zz;
                4: e_inc = zz;
                default: ;
            endcase
        end
        chk("ctrl", {24'd0, s_inc, s_inm, we3, wez, Op, dp_rst},
            {24'd0, e_inc, e_inm, e_we3, e_wez, e_op, e_dp});
        chk("status", {29'd0, running, halted, err},
            {29'd0, m_mode == 2, m_mode == 3, m_mode == 4});
        chk("retired", 32'(retired), 32'(m_ret));
        chk("taken", 32'(taken), 32'(m_tk));
        @(posedge clk);
        case (m_mode)
            0: if (st) begin m_mode = 2; m_ret = 0; m_tk = 0; end
            1: m_mode = 2;
            2: begin
                if (k == 6) begin
                    m_mode = 4;
                end else begin
                    m_ret = (m_ret + 1) % (1 << CNT_W);
                    if (!e_inc && m_tk < (1 << TK_W) - 1) m_tk++;
                    if (k == 5) m_mode = 3;
                end
            end
            default: if (st) begin m_mode = 1; m_ret = 0; m_tk = 0; end
        endcase
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ctrl"}, {24'd0, s_inc, s_inm, we3, wez, Op, dp_rst}, 32'h81);
        chk({tag, "_status"}, {29'd0, running, halted, err}, 32'd0);
        chk({tag, "_retired"}, 32'(retired), 32'd0);
        chk({tag, "_taken"}, 32'(taken), 32'd0);
    endtask

    // Assert reset between edges and check outputs before any clock edge.
    task automatic async_reset();
        @(negedge clk);
        start = 1'b0;
        #2 reset = 1'b0;
        #1 check_reset_vals("arst");
        m_mode = 0; m_ret = 0; m_tk = 0;
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    function automatic logic [5:0] rand_op();
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 45) return 6'($urandom_range(32, 63));
        if (r < 60) return 6'($urandom_range(0, 3));
        if (r < 85) return 6'($urandom_range(4, 6));
        if (r < 90) return 6'd7;
        return 6'($urandom_range(8, 31));
    endfunction

    initial begin
        reset = 1'b0; start = 1'b0; Opcode = 6'd0; z = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_reset_vals("rst");
        @(negedge clk) reset = 1'b1;

        repeat (5) step(6'd0, 1'b0, 1'b0);
        step(6'd0, 1'b0, 1'b1);
        step(6'b101100, 1'b0, 1'b1);
        step(6'b000101, 1'b1, 1'b0);
        step(6'b000101, 1'b0, 1'b0);
        step(6'b000110, 1'b1, 1'b0);
        step(6'b000110, 1'b0, 1'b0);
        repeat (5) step(6'b000100, 1'b0, 1'b0);
        step(6'b000111, 1'b0, 1'b0);
        step(6'd0, 1'b0, 1'b0);
        step(6'd0, 1'b0, 1'b1);
        step(6'd0, 1'b0, 1'b0);
        step(6'b000010, 1'b0, 1'b0);
        step(6'b010000, 1'b0, 1'b0);
        step(6'd0, 1'b0, 1'b0);
        step(6'd0, 1'b0, 1'b1);
        step(6'd0, 1'b0, 1'b0);
        step(6'b100000, 1'b0, 1'b0);
        async_reset();
        step(6'd0, 1'b0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset();
            end else begin
                step(rand_op(), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
